// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg
//   Shared definitions for the SPI ADC scheduler slice.
//   - sched_state_e : frame sequencer states
//   - DEF_*         : default parameter values
//   - idx_width()   : bits needed to address one of n requesters
package adc_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    localparam int DEF_N_REQ      = 2;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_CLK_DIV    = 2;

    // Requester index width; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_scheduler_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. The search starts one position after the last
//   granted index and wraps; the pointer only moves when the owner
//   accepts the grant via grant_stb.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     req         : request vector (N_REQ)
//     grant_stb   : pulse; commit gnt_idx as the new priority pointer
//     gnt_valid   : at least one request is pending
//     gnt_idx     : index of the winning request (combinational)
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_stb,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_s;
    logic             gnt_valid_s;
    logic [IDX_W-1:0] gnt_idx_s;

    // Search from ptr+1 upward, wrapping, and take the first set request.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr_r) + i) % N_REQ);
            if (!gnt_valid_s && req[cand_s]) begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_valid_s = gnt_valid_s;
            end
        end
    end

    // Priority pointer; resets to the last index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= IDX_W'(N_REQ - 1);
        end else if (grant_stb) begin
            ptr_r <= gnt_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt_valid = gnt_valid_s;
    assign gnt_idx   = gnt_idx_s;

endmodule

// File: rtl/adc_spi_scheduler.sv
// adc_spi_scheduler
//   Shares one external SPI (mode 0) ADC between N_REQ requesters. A
//   round-robin winner is granted, a FRAME_BITS command frame carrying the
//   winner index as the channel address is shifted out, and the last DATA_W
//   bits returned by the ADC are delivered with the requester id and an
//   unsigned "sample > threshold" flag.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     req         : level requests, held until ack
//     ack         : one-hot pulse to the served requester, with data_valid
//     threshold   : compare level, sampled when the result is produced
//     data_valid  : one-cycle pulse, new result on data_out/data_id/cmp_gt
//     data_out    : captured sample, held until the next result
//     data_id     : requester index of data_out
//     cmp_gt      : data_out > threshold
//     busy        : sequencer not idle
//     cs_n, sck, mosi, miso : ADC SPI pins (sck idles low)
module adc_spi_scheduler
    import adc_sched_pkg::*;
#(
    parameter  int N_REQ      = DEF_N_REQ,
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int FRAME_BITS = DEF_FRAME_BITS,
    parameter  int CLK_DIV    = DEF_CLK_DIV,
    localparam int IDX_W      = idx_width(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  ack,
    input  logic [DATA_W-1:0] threshold,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [IDX_W-1:0]  data_id,
    output logic              cmp_gt,
    output logic              busy,
    output logic              cs_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    // Command word: start bit, channel address, then zero padding.
    function automatic logic [FRAME_BITS-1:0] build_cmd(input logic [IDX_W-1:0] idx);
        logic [FRAME_BITS-1:0] c;
        c                         = '0;
        c[FRAME_BITS-1]           = 1'b1;
        c[FRAME_BITS-2 -: IDX_W]  = idx;
        return c;
    endfunction

    sched_state_e            state_r,  state_s;
    logic [DIV_W-1:0]        div_r,    div_s;
    logic [BIT_W-1:0]        bit_r,    bit_s;
    logic [FRAME_BITS-1:0]   cmd_r,    cmd_s;
    logic [DATA_W-1:0]       rx_r,     rx_s;
    logic [IDX_W-1:0]        gnt_r,    gnt_s;
    logic                    cs_n_r,   cs_n_s;
    logic                    sck_r,    sck_s;
    logic                    mosi_r,   mosi_s;
    logic [N_REQ-1:0]        ack_r,    ack_s;
    logic                    dv_r,     dv_s;
    logic [DATA_W-1:0]       dout_r,   dout_s;
    logic [IDX_W-1:0]        did_r,    did_s;
    logic                    cmp_r,    cmp_s;
    logic                    busy_r,   busy_s;
    logic                    grant_stb_s;
    logic                    arb_valid_s;
    logic [IDX_W-1:0]        arb_idx_s;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant_stb (grant_stb_s),
        .gnt_valid (arb_valid_s),
        .gnt_idx   (arb_idx_s)
    );

    // Sequencer next-state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        bit_s       = bit_r;
        cmd_s       = cmd_r;
        rx_s        = rx_r;
        gnt_s       = gnt_r;
        cs_n_s      = cs_n_r;
        sck_s       = sck_r;
        mosi_s      = mosi_r;
        ack_s       = '0;
        dv_s        = 1'b0;
        dout_s      = dout_r;
        did_s       = did_r;
        cmp_s       = cmp_r;
        grant_stb_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_s     = ST_SETUP;
                    grant_stb_s = 1'b1;
                    gnt_s       = arb_idx_s;
                    cmd_s       = build_cmd(arb_idx_s);
                    mosi_s      = 1'b1;
                    cs_n_s      = 1'b0;
                    sck_s       = 1'b0;
                    div_s       = '0;
                    bit_s       = '0;
                end else begin
                    cs_n_s = 1'b1;
                    sck_s  = 1'b0;
                    mosi_s = 1'b0;
                end
            end

            ST_SETUP: begin
                if (div_r == DIV_LAST) begin
                    state_s = ST_SHIFT;
                    div_s   = '0;
                    sck_s   = 1'b1;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end

            ST_SHIFT: begin
                if (sck_r) begin
                    // First cycle after the rising edge: ADC data has settled.
                    if (div_r == '0) begin
                        rx_s = {rx_r[DATA_W-2:0], miso};
                    end else begin
                        rx_s = rx_r;
                    end
                    if (div_r == DIV_LAST) begin
                        sck_s  = 1'b0;
                        div_s  = '0;
                        cmd_s  = cmd_r << 1;
                        mosi_s = cmd_r[FRAME_BITS-2];
                    end else begin
                        div_s = div_r + DIV_W'(1);
                    end
                end else begin
                    if (div_r == DIV_LAST) begin
                        div_s = '0;
                        if (bit_r == BIT_LAST) begin
                            state_s = ST_HOLD;
                            cs_n_s  = 1'b1;
                            mosi_s  = 1'b0;
                        end else begin
                            bit_s = bit_r + BIT_W'(1);
                            sck_s = 1'b1;
                        end
                    end else begin
                        div_s = div_r + DIV_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (div_r == DIV_LAST) begin
                    state_s = ST_DONE;
                    div_s   = '0;
                    dv_s    = 1'b1;
                    ack_s   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_r;
                    dout_s  = rx_r;
                    did_s   = gnt_r;
                    cmp_s   = (rx_r > threshold);
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                cs_n_s  = 1'b1;
                sck_s   = 1'b0;
                mosi_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            div_r   <= '0;
            bit_r   <= '0;
            cmd_r   <= '0;
            rx_r    <= '0;
            gnt_r   <= '0;
            cs_n_r  <= 1'b1;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            ack_r   <= '0;
            dv_r    <= 1'b0;
            dout_r  <= '0;
            did_r   <= '0;
            cmp_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            bit_r   <= bit_s;
            cmd_r   <= cmd_s;
            rx_r    <= rx_s;
            gnt_r   <= gnt_s;
            cs_n_r  <= cs_n_s;
            sck_r   <= sck_s;
            mosi_r  <= mosi_s;
            ack_r   <= ack_s;
            dv_r    <= dv_s;
            dout_r  <= dout_s;
            did_r   <= did_s;
            cmp_r   <= cmp_s;
            busy_r  <= busy_s;
        end
    end

    assign cs_n       = cs_n_r;
    assign sck        = sck_r;
    assign mosi       = mosi_r;
    assign ack        = ack_r;
    assign data_valid = dv_r;
    assign data_out   = dout_r;
    assign data_id    = did_r;
    assign cmp_gt     = cmp_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_adc_spi_scheduler.sv
// tb_adc_spi_scheduler
//   Randomized bench for adc_spi_scheduler with default parameters. A
//   behavioural mode-0 ADC drives miso, a pin monitor checks SPI timing and
//   the command frame, and a round-robin model predicts each grant.
module tb_adc_spi_scheduler;

    localparam int N_REQ   = 2;
    localparam int DATA_W  = 12;
    localparam int FRAME   = 16;
    localparam int CLK_DIV = 2;
    localparam int LATENCY = CLK_DIV * (2 * FRAME + 2);

    logic              clk;
    logic              rst_n;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  ack;
    logic [DATA_W-1:0] threshold;
    logic              data_valid;
    logic [DATA_W-1:0] data_out;
    logic [0:0]        data_id;
    logic              cmp_gt;
    logic              busy;
    logic              cs_n;
    logic              sck;
    logic              mosi;
    logic              miso;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference state
    int          last_gnt;
    logic [15:0] exp_cmd    = 16'h0000;
    logic [15:0] adc_frame  = 16'h0000;

    // Pin monitor state
    int          mon_rises    = 0;
    int          mon_falls    = FRAME;
    int          mon_run      = 0;
    int          cs_high_run  = 0;
    int          cs_fall_cyc  = 0;
    logic [15:0] mon_frame    = 16'h0000;
    logic        sck_prev     = 1'b0;
    logic        cs_n_prev    = 1'b1;

    adc_spi_scheduler #(
        .N_REQ      (N_REQ),
        .DATA_W     (DATA_W),
        .FRAME_BITS (FRAME),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .threshold  (threshold),
        .data_valid (data_valid),
        .data_out   (data_out),
        .data_id    (data_id),
        .cmp_gt     (cmp_gt),
        .busy       (busy),
        .cs_n       (cs_n),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 ADC: bit k of the frame is presented until the k-th falling sck.
    assign miso = (mon_falls < FRAME) ? adc_frame[FRAME - 1 - mon_falls] : 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Round-robin reference: first pending request after the last winner.
    function automatic int model_grant(input logic [N_REQ-1:0] pat);
        for (int i = 1; i <= N_REQ; i++) begin
            if (pat[(last_gnt + i) % N_REQ]) return (last_gnt + i) % N_REQ;
        end
        return -1;
    endfunction

    // SPI pin monitor: sck phase lengths, cs_n setup/gap, rise count, mosi frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_rises   = 0;
            mon_falls   = FRAME;
            mon_run     = 0;
            cs_high_run = 0;
        end else begin
            if (cs_n_prev && !cs_n) begin
                chk_eq("cs_gap", 32'(cs_high_run >= CLK_DIV), 32'd1);
                mon_rises   = 0;
                mon_falls   = 0;
                mon_frame   = 16'h0000;
                cs_fall_cyc = cyc;
            end
            if (!cs_n_prev && cs_n) begin
                chk_eq("sck_rises", mon_rises, FRAME);
                chk_eq("mosi_frame", 32'(mon_frame), 32'(exp_cmd));
                cs_high_run = 0;
            end
            if (cs_n) cs_high_run++;
            if (sck && !sck_prev) begin
                chk_eq("sck_under_cs", 32'(cs_n), 32'd0);
                if (mon_rises == 0) chk_eq("cs_setup", cyc - cs_fall_cyc, CLK_DIV);
                else                chk_eq("sck_low", mon_run, CLK_DIV);
                mon_frame = {mon_frame[14:0], mosi};
                mon_rises++;
                mon_run = 1;
            end else if (!sck && sck_prev) begin
                chk_eq("sck_high", mon_run, CLK_DIV);
                mon_falls++;
                mon_run = 1;
            end else begin
                mon_run++;
            end
        end
        sck_prev  = sck;
        cs_n_prev = cs_n;
    end

    // One complete transaction: raise pat, wait for the result, check it, drop req.
    task automatic do_frame(input logic [N_REQ-1:0] pat, input logic [15:0] frame,
                            input logic [DATA_W-1:0] thr);
        int   g;
        logic seen;
        g         = model_grant(pat);
        exp_cmd   = 16'h8000 | (16'(g) << 14);
        adc_frame = frame;
        threshold = thr;
        req       = pat;
        seen      = 1'b0;
        for (int k = 0; k < 4 * LATENCY && !seen; k++) begin
            @(negedge clk);
            if (data_valid) seen = 1'b1;
        end
        if (!seen) begin
            chk_eq("dv_timeout", 32'd0, 32'd1);
            req = '0;
            return;
        end
        chk_eq("latency",  cyc - cs_fall_cyc, LATENCY);
        chk_eq("data_out", 32'(data_out), 32'(frame[DATA_W-1:0]));
        chk_eq("data_id",  32'(data_id), g);
        chk_eq("ack",      32'(ack), 32'(1 << g));
        chk_eq("cmp_gt",   32'(cmp_gt), 32'(frame[DATA_W-1:0] > thr));
        chk_eq("busy_done", 32'(busy), 32'd1);
        last_gnt = g;
        req      = '0;
        @(negedge clk);
        chk_eq("dv_pulse",  32'(data_valid), 32'd0);
        chk_eq("ack_pulse", 32'(ack), 32'd0);
        chk_eq("busy_idle", 32'(busy), 32'd0);
        chk_eq("data_hold", 32'(data_out), 32'(frame[DATA_W-1:0]));
    endtask

    initial begin
        int   act;
        logic hit;
        rst_n     = 1'b0;
        req       = '0;
        threshold = '0;
        last_gnt  = N_REQ - 1;

        // Reset values
        repeat (3) @(negedge clk);
        chk_eq("rst_cs_n", 32'(cs_n), 32'd1);
        chk_eq("rst_sck",  32'(sck), 32'd0);
        chk_eq("rst_mosi", 32'(mosi), 32'd0);
        chk_eq("rst_ack",  32'(ack), 32'd0);
        chk_eq("rst_dv",   32'(data_valid), 32'd0);
        chk_eq("rst_dout", 32'(data_out), 32'd0);
        chk_eq("rst_did",  32'(data_id), 32'd0);
        chk_eq("rst_cmp",  32'(cmp_gt), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (!cs_n || sck || busy || data_valid || (ack != '0)) act++;
        end
        chk_eq("idle_quiet", act, 0);

        // Single request, known sample
        do_frame(2'b01, 16'h0ABC, 12'hFFF);

        // Both requesting: alternating grants
        repeat (4) do_frame(2'b11, 16'($urandom), 12'($urandom));

        // Threshold boundaries
        do_frame(2'b01, 16'h0800, 12'h800);
        do_frame(2'b10, 16'h5801, 12'h800);
        do_frame(2'b11, 16'hAFFF, 12'h800);
        do_frame(2'b11, 16'h37FF, 12'h800);
        do_frame(2'b11, 16'h0000, 12'h000);

        // Randomized traffic
        repeat (12) do_frame(2'($urandom_range(1, 3)), 16'($urandom), 12'($urandom));

        // Reset in the middle of SHIFT
        exp_cmd   = 16'h0000;
        adc_frame = 16'($urandom);
        req       = 2'b01;
        hit       = 1'b0;
        for (int k = 0; k < 4 * LATENCY && !hit; k++) begin
            @(posedge clk);
            if (mon_rises == 7) hit = 1'b1;
        end
        chk_eq("abort_reach", 32'(hit), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("abort_cs_n", 32'(cs_n), 32'd1);
        chk_eq("abort_sck",  32'(sck), 32'd0);
        chk_eq("abort_busy", 32'(busy), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        last_gnt = N_REQ - 1;
        act = 0;
        repeat (2 * LATENCY) begin
            @(negedge clk);
            if (data_valid || !cs_n) act++;
        end
        chk_eq("abort_no_dv", act, 0);
        do_frame(2'b11, 16'($urandom), 12'($urandom));
        do_frame(2'b11, 16'($urandom), 12'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
